fetch_unit: RTL and testbench

Instruction-fetch front end for the pipelined MIPS core. It owns the fetch PC, drives the combinational instruction memory address, and buffers fetched `{pc, instr}` pairs in a small queue. Decode consumes those pairs over a valid/ready handshake. Branch and jump resolution downstream steers it through a single-cycle redirect that flushes all buffered, wrong-path instructions.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_fifo.sv | 85 ++++++++
 rtl/fetch_unit.sv | 119 +++++++++++
 tb/tb_fetch_unit.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction-fetch front end.
//   FETCH_RESET_PC : default fetch PC after reset
//   PC_INC         : sequential fetch stride in bytes
//   fetch_entry_t  : one buffered {pc, instr} pair
package fetch_pkg;

  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] PC_INC         = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: circular queue of fetch_entry_t between fetch and decode.
// Ports:
//   clk, reset      : clock, async active-high reset (clears storage too)
//   push, din       : write din at the tail (ignored when full without pop)
//   pop             : drop the head (ignored when empty)
//   flush           : discard all entries; overrides push and pop
//   head            : entry at the read pointer (stale when empty)
//   full, empty     : occupancy flags
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t   mem_q [DEPTH];
  fetch_entry_t   mem_d [DEPTH];
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // When full, a same-cycle pop frees the slot the write lands in
  // (wr_ptr == rd_ptr), so push+pop while full is safe.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end. Owns the fetch PC, addresses the
// combinational IM, buffers {pc, instr} pairs and hands them to decode over
// valid/ready. A one-cycle redirect flushes the queue and restarts fetch.
// Ports:
//   clk, reset               : clock, async active-high reset
//   im_addr / im_instr       : IM address out, IM data in (same cycle)
//   redirect / redirect_pc   : flush + restart request and its target
//   out_valid / out_ready    : head handshake with decode
//   out_pc/out_instr/out_pc4 : head entry and its link value (pc + 4)
//   align_err                : sticky misaligned-redirect flag
// Optional feature macro: FETCH_ALIGN_CHECK_EN (adds align_err and a halt on
// a misaligned redirect target; without it the low target bits are dropped).
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = FETCH_RESET_PC,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] im_addr,
  input  logic [31:0] im_instr,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc4
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic        align_err
`endif
);

  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic         halted;
  logic         pop, push;
  logic         fifo_full, fifo_empty;
  fetch_entry_t fifo_din, fifo_head;

`ifdef FETCH_ALIGN_CHECK_EN
  logic halted_q, halted_d;
  logic align_err_q, align_err_d;

  always_comb begin
    halted_d    = halted_q;
    align_err_d = align_err_q;
    if (redirect && (redirect_pc[1:0] != 2'b00)) begin
      halted_d    = 1'b1;
      align_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      halted_q    <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      halted_q    <= halted_d;
      align_err_q <= align_err_d;
    end
  end

  assign halted    = halted_q;
  assign align_err = align_err_q;
`else
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign halted = 1'b0;
`endif

  assign im_addr   = fetch_pc_q;
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  // Redirect wins over push: the IM word at the old PC is wrong-path.
  assign push      = !redirect && !halted && (!fifo_full || pop);

  assign fifo_din.pc    = fetch_pc_q;
  assign fifo_din.instr = im_instr;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
    end else if (push) begin
      fetch_pc_d = fetch_pc_q + PC_INC;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
    end else begin
      fetch_pc_q <= fetch_pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .din   (fifo_din),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Head outputs come from queue storage only; storage is cleared on reset,
  // so out_pc4 reads 4 out of reset.
  assign out_pc    = fifo_head.pc;
  assign out_instr = fifo_head.instr;
  assign out_pc4   = fifo_head.pc + PC_INC;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam int          QD    = 2;
  localparam logic [31:0] RPC   = 32'h0000_3000;
  localparam logic [31:0] IMXOR = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] im_addr;
  logic [31:0] im_instr;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [31:0] out_pc4;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        align_err;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign im_instr = im_addr ^ IMXOR;

  fetch_unit #(
    .RESET_PC (RPC),
    .QDEPTH   (QD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .im_addr     (im_addr),
    .im_instr    (im_instr),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_instr   (out_instr),
    .out_pc4     (out_pc4)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .align_err   (align_err)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of PCs plus the next fetch address.
  logic [31:0] m_pc = RPC;
  logic [31:0] m_q[$];
  bit          m_halted = 1'b0;
  int          m_sz;
  bit          m_pop;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pc = RPC;
      m_q.delete();
      m_halted = 1'b0;
    end else begin
      m_sz  = m_q.size();
      m_pop = (m_sz > 0) && out_ready;
      if (redirect) begin
        m_q.delete();
`ifdef FETCH_ALIGN_CHECK_EN
        if (redirect_pc[1:0] != 2'b00) m_halted = 1'b1;
`endif
        m_pc = redirect_pc & 32'hFFFF_FFFC;
      end else begin
        if (m_pop) void'(m_q.pop_front());
        if (!m_halted && (m_sz < QD || m_pop)) begin
          m_q.push_back(m_pc);
          m_pc = m_pc + 32'd4;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("model_valid", {31'b0, out_valid}, {31'b0, (m_q.size() != 0)});
    chk("model_im_addr", im_addr, m_pc);
    if (m_q.size() != 0) begin
      chk("model_out_pc", out_pc, m_q[0]);
      chk("model_out_instr", out_instr, m_q[0] ^ IMXOR);
      chk("model_out_pc4", out_pc4, m_q[0] + 32'd4);
    end
`ifdef FETCH_ALIGN_CHECK_EN
    chk("model_align_err", {31'b0, align_err}, {31'b0, m_halted});
`endif
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    // 1. reset values and streaming fetch
    tick();
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_pc4", out_pc4, 32'h4);
    chk("rst_im_addr", im_addr, 32'h3000);
`ifdef FETCH_ALIGN_CHECK_EN
    chk("rst_align_err", {31'b0, align_err}, 32'd0);
`endif
    reset = 1'b0;
    tick();
    chk("s1_valid", {31'b0, out_valid}, 32'd1);
    chk("s1_pc0", out_pc, 32'h3000);
    chk("s1_instr0", out_instr, 32'hA5A5_3000);
    chk("s1_pc4_0", out_pc4, 32'h3004);
    tick();
    chk("s1_pc1", out_pc, 32'h3004);
    tick();
    chk("s1_pc2", out_pc, 32'h3008);
    chk("s1_instr2", out_instr, 32'hA5A5_3008);

    // 2. stall fills the queue, then drain without gaps
    out_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) tick();
    chk("s2_stall_head", out_pc, 32'h3000);
    chk("s2_stall_im", im_addr, 32'h3008);
    out_ready = 1'b1;
    tick();
    chk("s2_pop0", out_pc, 32'h3004);
    tick();
    chk("s2_pop1", out_pc, 32'h3008);
    tick();
    chk("s2_pop2", out_pc, 32'h300C);
    tick();
    chk("s3_head", out_pc, 32'h3010);

    // 3. redirect with a pending pop
    redirect = 1'b1;
    redirect_pc = 32'h0000_3100;
    tick();
    redirect = 1'b0;
    chk("s3_bubble", {31'b0, out_valid}, 32'd0);
    chk("s3_im", im_addr, 32'h3100);
    tick();
    chk("s3_tgt", out_pc, 32'h3100);
    tick();
    chk("s3_tgt1", out_pc, 32'h3104);

    // 4. PC wrap-around
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    tick();
    chk("s4_pc", out_pc, 32'hFFFF_FFFC);
    chk("s4_instr", out_instr, 32'h5A5A_FFFC);
    chk("s4_pc4", out_pc4, 32'h0);
    tick();
    chk("s4_wrap", out_pc, 32'h0);
    chk("s4_wrap_pc4", out_pc4, 32'h4);

    // 5. misaligned redirect target
    redirect = 1'b1;
    redirect_pc = 32'h0000_3102;
    tick();
    redirect = 1'b0;
    chk("s5_bubble", {31'b0, out_valid}, 32'd0);
    chk("s5_im", im_addr, 32'h3100);
`ifdef FETCH_ALIGN_CHECK_EN
    chk("s5_align_err", {31'b0, align_err}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("s5_halt_valid", {31'b0, out_valid}, 32'd0);
    end
    do_reset();
    chk("s5_err_clr", {31'b0, align_err}, 32'd0);
    chk("s5_restart_im", im_addr, 32'h3000);
    tick();
    chk("s5_restart", out_pc, 32'h3000);
`else
    tick();
    chk("s5_resume", out_pc, 32'h3100);
    tick();
    chk("s5_resume1", out_pc, 32'h3104);
`endif

    // 6. async reset between edges with a full queue
    out_ready = 1'b0;
    tick();
    tick();
    tick();
    chk("s6_pre_valid", {31'b0, out_valid}, 32'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("s6_async_valid", {31'b0, out_valid}, 32'd0);
    chk("s6_async_im", im_addr, 32'h3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
